// File: rtl/mxu_out_row_fifo_pkg.sv
// mxu_out_row_fifo_pkg: array geometry, PE command encoding and row type shared by the output row FIFO
package mxu_out_row_fifo_pkg;
  localparam int ARRAY_DIMENSION = 4;
  localparam int FLOAT_SIZE = 16;
  localparam int PE_COMMAND_WIDTH = 4;
  localparam logic [PE_COMMAND_WIDTH-1:0] PE_CMD_OUTPUT = 4'h6;
  typedef logic [ARRAY_DIMENSION-1:0][FLOAT_SIZE-1:0] Out_Row;
endpackage

// File: rtl/mxu_out_row_fifo_credit.sv
// row_credit_counter: tracks output rows in flight through the array and issues credits to the sequencer
module row_credit_counter #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_out,
  input  logic                       arrive,
  input  logic                       err_clear,
  input  logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       can_issue,
  output logic                       err_orphan,
  output logic                       err_credit
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] in_flight;
  logic [CW:0] total;
  logic empty, full;
  assign empty = in_flight == '0;
  assign full = in_flight == CW'(DEPTH);
  assign total = {1'b0, count} + {1'b0, in_flight};
  assign can_issue = total < (CW + 1)'(DEPTH);
  // Net of issue minus arrive, clamped to [0, DEPTH]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= '0;
      err_orphan <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      if (issue_out & ~arrive & ~full) in_flight <= in_flight + 1'b1;
      else if (arrive & ~issue_out & ~empty) in_flight <= in_flight - 1'b1;
      err_orphan <= (arrive & empty) | (err_orphan & ~err_clear);
      err_credit <= (issue_out & ~can_issue) | (err_credit & ~err_clear);
    end
  end
endmodule

// File: rtl/mxu_out_row_fifo.sv
// mxu_out_row_fifo: captures de-skewed output rows into a credited show-ahead FIFO for writeback
module mxu_out_row_fifo
  import mxu_out_row_fifo_pkg::*;
#(
  parameter int NUM_DATA = ARRAY_DIMENSION,
  parameter int DATA_SIZE = FLOAT_SIZE,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DATA*DATA_SIZE-1:0] row_data,
  input  logic [PE_COMMAND_WIDTH-1:0]   row_command,
  input  logic                          issue_out,
  output logic                          can_issue,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_DATA*DATA_SIZE-1:0] out_data,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  input  logic                          err_clear,
  output logic                          err_overflow,
  output logic                          err_orphan,
  output logic                          err_credit
);
  localparam int W = NUM_DATA * DATA_SIZE;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic arrive, push, pop;
  assign arrive = row_command == PE_CMD_OUTPUT;
  assign out_valid = count != '0;
  assign pop = out_valid & out_ready;
  // A full FIFO still accepts a row when the head leaves in the same cycle
  assign push = arrive & ((count < CW'(DEPTH)) | pop);
  assign out_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= row_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      err_overflow <= (arrive & ~push) | (err_overflow & ~err_clear);
    end
  end
  row_credit_counter #(.DEPTH(DEPTH)) u_credit (
    .clk(clk),
    .rst(rst),
    .issue_out(issue_out),
    .arrive(arrive),
    .err_clear(err_clear),
    .count(count),
    .can_issue(can_issue),
    .err_orphan(err_orphan),
    .err_credit(err_credit)
  );
endmodule

// File: tb/tb_mxu_out_row_fifo.sv
// tb_mxu_out_row_fifo: directed and random stimulus against a queue-based reference model
module tb_mxu_out_row_fifo;
  import mxu_out_row_fifo_pkg::*;
  localparam int ND = 4, DS = 16, DEPTH = 4;
  logic clk = 0, rst = 1;
  logic [ND*DS-1:0] row_data = '0, out_data;
  logic [PE_COMMAND_WIDTH-1:0] row_command = '0;
  logic issue_out = 0, out_ready = 0, err_clear = 0;
  logic can_issue, out_valid, err_overflow, err_orphan, err_credit;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  int inf = 0;
  bit m_ovf = 0, m_orph = 0, m_cred = 0;

  mxu_out_row_fifo #(.NUM_DATA(ND), .DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .row_data(row_data), .row_command(row_command),
    .issue_out(issue_out), .can_issue(can_issue), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count), .err_clear(err_clear),
    .err_overflow(err_overflow), .err_orphan(err_orphan), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("count", 64'(count), 64'(q.size()));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) check("out_data", out_data, q[0]);
    check("can_issue", 64'(can_issue), 64'(q.size() + inf < DEPTH));
    check("err_overflow", 64'(err_overflow), 64'(m_ovf));
    check("err_orphan", 64'(err_orphan), 64'(m_orph));
    check("err_credit", 64'(err_credit), 64'(m_cred));
  endtask

  task automatic model_reset();
    q.delete();
    inf = 0;
    m_ovf = 0;
    m_orph = 0;
    m_cred = 0;
  endtask

  task automatic cyc(input bit iss, input bit arr, input logic [63:0] d, input bit rdy, input bit clr);
    logic [PE_COMMAND_WIDTH-1:0] c;
    bit pop, push, can;
    @(negedge clk);
    check_outputs();
    c = PE_COMMAND_WIDTH'($urandom_range(0, 15));
    if (c == PE_CMD_OUTPUT) c = ~c;
    issue_out = iss;
    row_command = arr ? PE_CMD_OUTPUT : c;
    row_data = d;
    out_ready = rdy;
    err_clear = clr;
    pop = (q.size() != 0) && rdy;
    can = q.size() + inf < DEPTH;
    push = arr && (q.size() < DEPTH || pop);
    m_ovf = (arr && !push) || (m_ovf && !clr);
    m_orph = (arr && inf == 0) || (m_orph && !clr);
    m_cred = (iss && !can) || (m_cred && !clr);
    inf = inf + int'(iss) - int'(arr);
    if (inf < 0) inf = 0;
    if (inf > DEPTH) inf = DEPTH;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
  endtask

  function automatic logic [63:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 0;
    cyc(1, 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 64'h0004_0003_0002_0001, 1, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    repeat (4) cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, rnd(), 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, rnd(), 0, 0);
    cyc(0, 1, rnd(), 1, 0);
    cyc(0, 1, rnd(), 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, rnd(), 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 1, 1);
    repeat (4) cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, rnd(), 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("pre_reset_count", 64'(q.size()), 64'd3);
    check("pre_reset_inflight", 64'(inf), 64'd1);
    issue_out = 0;
    row_command = '0;
    out_ready = 0;
    err_clear = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check("async_count", 64'(count), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_can_issue", 64'(can_issue), 64'd1);
    check("async_errs", {61'd0, err_overflow, err_orphan, err_credit}, 64'd0);
    @(negedge clk);
    rst = 0;
    cyc(0, 1, rnd(), 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (3000) cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, rnd(),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    cyc(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
